// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard/forwarding controller.
//   FWD_RF/FWD_EX/FWD_MEM/FWD_WB : forwarding select encodings
//   state_t                     : hazard FSM states (RUN, STALL)
//   REG_PC                      : register number that is always read from the PC path
//   reg_match()                 : operand-vs-stage match rule
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Operand matches a stage only if it is read, the stage writes, the numbers
  // agree and the register is not the PC.
  function automatic logic reg_match(input logic       use_src,
                                     input logic       stage_en,
                                     input logic [3:0] src,
                                     input logic [3:0] stage_rd);
    return use_src && stage_en && (src == stage_rd) && (src != REG_PC);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: per-operand stage match and forwarding select.
//   src, use_src            : ID-stage operand register number and read flag
//   ex_/mem_/wb_rd, *_rf_en : stage destination registers and write enables
//   sel                     : youngest matching stage (EX > MEM > WB), else FWD_RF
//   match_ex/mem/wb         : raw per-stage match bits
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned FWD_W = 2
) (
  input  logic [3:0]       src,
  input  logic             use_src,
  input  logic [3:0]       ex_rd,
  input  logic             ex_rf_en,
  input  logic [3:0]       mem_rd,
  input  logic             mem_rf_en,
  input  logic [3:0]       wb_rd,
  input  logic             wb_rf_en,
  output logic [FWD_W-1:0] sel,
  output logic             match_ex,
  output logic             match_mem,
  output logic             match_wb
);

  assign match_ex  = reg_match(use_src, ex_rf_en,  src, ex_rd);
  assign match_mem = reg_match(use_src, mem_rf_en, src, mem_rd);
  assign match_wb  = reg_match(use_src, wb_rf_en,  src, wb_rd);

  always_comb begin
    sel = FWD_W'(FWD_RF);
    if (match_ex)       sel = FWD_W'(FWD_EX);
    else if (match_mem) sel = FWD_W'(FWD_MEM);
    else if (match_wb)  sel = FWD_W'(FWD_WB);
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard and forwarding controller for the five-stage core.
//   Config macro HAZARD_FWD_EN: when defined, forwarding is active and only
//   load-use hazards stall (1 cycle); otherwise fwd_* are 00 and any EX/MEM/WB
//   match stalls for 3/2/1 cycles.
// Ports:
//   clk, reset_n (sync, active low)
//   id_rn/id_rm/id_rd + id_use_*    : ID-stage source operands
//   ex_rd/ex_rf_en/ex_load          : EX-stage destination
//   mem_rd/mem_rf_en, wb_rd/wb_rf_en: MEM/WB-stage destinations
//   branch_taken                    : taken branch resolved in EX
//   cu_sel, pc_en, ifid_en, ifid_clr: pipeline control (combinational)
//   fwd_rn/fwd_rm/fwd_rd            : forwarding selects (combinational)
//   stall_cnt, flush_cnt            : saturating event counters (registered)
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned FWD_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic [3:0]       ex_rd,
  input  logic             ex_rf_en,
  input  logic             ex_load,
  input  logic [3:0]       mem_rd,
  input  logic             mem_rf_en,
  input  logic [3:0]       wb_rd,
  input  logic             wb_rf_en,
  input  logic             branch_taken,
  output logic             cu_sel,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic [FWD_W-1:0] fwd_rn,
  output logic [FWD_W-1:0] fwd_rm,
  output logic [FWD_W-1:0] fwd_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [FWD_W-1:0] sel_rn, sel_rm, sel_rd;
  logic [2:0]       m_ex, m_mem, m_wb;
  logic             any_ex, any_mem, any_wb;
  logic             hazard;
  logic [1:0]       stall_len;
  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;

  hazard_fwd_sel #(.FWD_W(FWD_W)) u_sel_rn (
    .src(id_rn), .use_src(id_use_rn),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en),
    .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
    .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
    .sel(sel_rn), .match_ex(m_ex[0]), .match_mem(m_mem[0]), .match_wb(m_wb[0])
  );

  hazard_fwd_sel #(.FWD_W(FWD_W)) u_sel_rm (
    .src(id_rm), .use_src(id_use_rm),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en),
    .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
    .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
    .sel(sel_rm), .match_ex(m_ex[1]), .match_mem(m_mem[1]), .match_wb(m_wb[1])
  );

  hazard_fwd_sel #(.FWD_W(FWD_W)) u_sel_rd (
    .src(id_rd), .use_src(id_use_rd),
    .ex_rd(ex_rd), .ex_rf_en(ex_rf_en),
    .mem_rd(mem_rd), .mem_rf_en(mem_rf_en),
    .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
    .sel(sel_rd), .match_ex(m_ex[2]), .match_mem(m_mem[2]), .match_wb(m_wb[2])
  );

  assign any_ex  = |m_ex;
  assign any_mem = |m_mem;
  assign any_wb  = |m_wb;

`ifdef HAZARD_FWD_EN
  assign hazard    = ex_load & any_ex;
  assign stall_len = 2'd1;

  logic unused_match;
  assign unused_match = any_mem | any_wb;

  always_comb begin
    fwd_rn = '0;
    fwd_rm = '0;
    fwd_rd = '0;
    if (reset_n) begin
      fwd_rn = sel_rn;
      fwd_rm = sel_rm;
      fwd_rd = sel_rd;
    end
  end
`else
  assign hazard    = any_ex | any_mem | any_wb;
  assign stall_len = any_ex ? 2'd3 : (any_mem ? 2'd2 : 2'd1);

  logic unused_fwd;
  assign unused_fwd = ^{sel_rn, sel_rm, sel_rd, ex_load};

  always_comb begin
    fwd_rn = '0;
    fwd_rm = '0;
    fwd_rd = '0;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state. The hazard cycle itself is the first stall cycle, so STALL
  // holds the remaining len-1 cycles; a 1-cycle stall never leaves RUN.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      RUN: begin
        if (hazard && !branch_taken && (stall_len > 2'd1)) begin
          state_d = STALL;
          rem_d   = stall_len - 2'd1;
        end
      end
      STALL: begin
        if (branch_taken || (rem_q <= 2'd1)) begin
          state_d = RUN;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end
      default: begin
        state_d = RUN;
        rem_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    cu_sel   = 1'b1;
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    ifid_clr = 1'b0;
    if (!reset_n) begin
      cu_sel   = 1'b0;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      ifid_clr = 1'b1;
    end else if (branch_taken) begin
      cu_sel   = 1'b0;
      ifid_clr = 1'b1;
    end else if ((state_q == STALL) || hazard) begin
      cu_sel  = 1'b0;
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end
  end

  // Event counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_taken && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
